// File: rtl/y86_pkg.sv
// Y86-64 shared encodings, widths and the E pipeline-register payload.
package y86_pkg;

    localparam int unsigned W  = 64;
    localparam int unsigned IW = 4;
    localparam int unsigned SW = 3;
    localparam int unsigned RW = 4;

    localparam logic [IW-1:0] I_HALT   = 4'h0;
    localparam logic [IW-1:0] I_NOP    = 4'h1;
    localparam logic [IW-1:0] I_CMOVXX = 4'h2;
    localparam logic [IW-1:0] I_IRMOVQ = 4'h3;
    localparam logic [IW-1:0] I_RMMOVQ = 4'h4;
    localparam logic [IW-1:0] I_MRMOVQ = 4'h5;
    localparam logic [IW-1:0] I_OPQ    = 4'h6;
    localparam logic [IW-1:0] I_JXX    = 4'h7;
    localparam logic [IW-1:0] I_CALL   = 4'h8;
    localparam logic [IW-1:0] I_RET    = 4'h9;
    localparam logic [IW-1:0] I_PUSHQ  = 4'hA;
    localparam logic [IW-1:0] I_POPQ   = 4'hB;

    localparam logic [SW-1:0] S_AOK = 3'd1;
    localparam logic [SW-1:0] S_HLT = 3'd2;
    localparam logic [SW-1:0] S_ADR = 3'd3;
    localparam logic [SW-1:0] S_INS = 3'd4;

    localparam logic [RW-1:0] RNONE = 4'hF;

    localparam logic [IW-1:0] ALU_ADD = 4'h0;
    localparam logic [IW-1:0] ALU_SUB = 4'h1;
    localparam logic [IW-1:0] ALU_AND = 4'h2;
    localparam logic [IW-1:0] ALU_XOR = 4'h3;

    localparam logic [IW-1:0] C_YES = 4'h0;
    localparam logic [IW-1:0] C_LE  = 4'h1;
    localparam logic [IW-1:0] C_L   = 4'h2;
    localparam logic [IW-1:0] C_E   = 4'h3;
    localparam logic [IW-1:0] C_NE  = 4'h4;
    localparam logic [IW-1:0] C_GE  = 4'h5;
    localparam logic [IW-1:0] C_G   = 4'h6;

    typedef struct packed {
        logic [SW-1:0] stat;
        logic [IW-1:0] icode;
        logic [IW-1:0] ifun;
        logic [W-1:0]  valc;
        logic [W-1:0]  vala;
        logic [W-1:0]  valb;
        logic [RW-1:0] srca;
        logic [RW-1:0] srcb;
        logic [RW-1:0] dste;
        logic [RW-1:0] dstm;
    } e_reg_t;

    localparam e_reg_t E_BUBBLE = '{
        stat:  S_AOK,
        icode: I_NOP,
        ifun:  4'h0,
        valc:  64'h0,
        vala:  64'h0,
        valb:  64'h0,
        srca:  RNONE,
        srcb:  RNONE,
        dste:  RNONE,
        dstm:  RNONE
    };

    // A faulting downstream stage must freeze the condition codes.
    function automatic logic stat_exc(input logic [SW-1:0] s);
        return (s == S_ADR) || (s == S_INS) || (s == S_HLT);
    endfunction

endpackage

// File: rtl/execute_if.sv
// Decode-to-execute bus and execute-stage results.
interface execute_if;
    import y86_pkg::*;

    logic          E_bubble;
    logic [SW-1:0] D_stat;
    logic [IW-1:0] D_icode;
    logic [IW-1:0] D_ifun;
    logic [W-1:0]  D_valC;
    logic [W-1:0]  d_valA;
    logic [W-1:0]  d_valB;
    logic [RW-1:0] d_srcA;
    logic [RW-1:0] d_srcB;
    logic [RW-1:0] d_dstE;
    logic [RW-1:0] d_dstM;
    logic [SW-1:0] m_stat;
    logic [SW-1:0] W_stat;

    logic [SW-1:0] E_stat;
    logic [IW-1:0] E_icode;
    logic [IW-1:0] E_ifun;
    logic [W-1:0]  E_valC;
    logic [W-1:0]  E_valA;
    logic [W-1:0]  E_valB;
    logic [RW-1:0] E_srcA;
    logic [RW-1:0] E_srcB;
    logic [RW-1:0] E_dstE;
    logic [RW-1:0] E_dstM;
    logic [W-1:0]  e_valE;
    logic [W-1:0]  e_valA;
    logic [RW-1:0] e_dstE;
    logic          e_Cnd;
    logic [2:0]    cc;

    modport master (
        output E_bubble, D_stat, D_icode, D_ifun, D_valC, d_valA, d_valB,
               d_srcA, d_srcB, d_dstE, d_dstM, m_stat, W_stat,
        input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
               E_srcA, E_srcB, E_dstE, E_dstM, e_valE, e_valA, e_dstE, e_Cnd, cc
    );

    modport slave (
        input  E_bubble, D_stat, D_icode, D_ifun, D_valC, d_valA, d_valB,
               d_srcA, d_srcB, d_dstE, d_dstM, m_stat, W_stat,
        output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
               E_srcA, E_srcB, E_dstE, E_dstM, e_valE, e_valA, e_dstE, e_Cnd, cc
    );

endinterface

// File: rtl/y86_alu.sv
// Combinational Y86-64 ALU: R = B op A with zero/sign/overflow flags.
module y86_alu
    import y86_pkg::*;
(
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [IW-1:0] fun,
    output logic [W-1:0]  r,
    output logic          zf,
    output logic          sf,
    output logic          of
);

    always_comb begin
        r  = b + a;
        of = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        case (fun)
            ALU_SUB: begin
                r  = b - a;
                of = (a[W-1] != b[W-1]) && (r[W-1] != b[W-1]);
            end
            ALU_AND: begin
                r  = b & a;
                of = 1'b0;
            end
            ALU_XOR: begin
                r  = b ^ a;
                of = 1'b0;
            end
            default: ;
        endcase
        zf = (r == '0);
        sf = r[W-1];
    end

endmodule

// File: rtl/execute.sv
// Y86-64 execute stage: E pipeline register, ALU operand selection,
// condition-code register, branch/cmov condition and cmov destination.
module execute
    import y86_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    execute_if.slave bus
);

    e_reg_t        e_q;
    e_reg_t        e_d;
    logic [2:0]    cc_q;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [IW-1:0] alu_fun;
    logic [W-1:0]  alu_r;
    logic          alu_zf;
    logic          alu_sf;
    logic          alu_of;
    logic          set_cc;
    logic          cnd;
    logic          zf;
    logic          sf;
    logic          of;

    always_comb begin
        e_d = '{
            stat:  bus.D_stat,
            icode: bus.D_icode,
            ifun:  bus.D_ifun,
            valc:  bus.D_valC,
            vala:  bus.d_valA,
            valb:  bus.d_valB,
            srca:  bus.d_srcA,
            srcb:  bus.d_srcB,
            dste:  bus.d_dstE,
            dstm:  bus.d_dstM
        };
        if (bus.E_bubble) begin
            e_d = E_BUBBLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q <= E_BUBBLE;
        end else begin
            e_q <= e_d;
        end
    end

    always_comb begin
        alu_a = '0;
        case (e_q.icode)
            I_CMOVXX, I_OPQ:             alu_a = e_q.vala;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = e_q.valc;
            I_CALL, I_PUSHQ:             alu_a = -W'(64'd8);
            I_RET, I_POPQ:               alu_a = W'(64'd8);
            default:                     alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (e_q.icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
            I_PUSHQ, I_RET, I_POPQ:       alu_b = e_q.valb;
            default:                     alu_b = '0;
        endcase
    end

    assign alu_fun = (e_q.icode == I_OPQ) ? e_q.ifun : ALU_ADD;

    y86_alu u_alu (
        .a   (alu_a),
        .b   (alu_b),
        .fun (alu_fun),
        .r   (alu_r),
        .zf  (alu_zf),
        .sf  (alu_sf),
        .of  (alu_of)
    );

    assign set_cc = (e_q.icode == I_OPQ) && !stat_exc(bus.m_stat) && !stat_exc(bus.W_stat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q <= 3'b100;
        end else if (set_cc) begin
            cc_q <= {alu_zf, alu_sf, alu_of};
        end
    end

    assign zf = cc_q[2];
    assign sf = cc_q[1];
    assign of = cc_q[0];

    always_comb begin
        cnd = 1'b0;
        case (e_q.ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = (sf ^ of) | zf;
            C_L:     cnd = sf ^ of;
            C_E:     cnd = zf;
            C_NE:    cnd = !zf;
            C_GE:    cnd = !(sf ^ of);
            C_G:     cnd = !(sf ^ of) & !zf;
            default: cnd = 1'b0;
        endcase
    end

    assign bus.E_stat  = e_q.stat;
    assign bus.E_icode = e_q.icode;
    assign bus.E_ifun  = e_q.ifun;
    assign bus.E_valC  = e_q.valc;
    assign bus.E_valA  = e_q.vala;
    assign bus.E_valB  = e_q.valb;
    assign bus.E_srcA  = e_q.srca;
    assign bus.E_srcB  = e_q.srcb;
    assign bus.E_dstE  = e_q.dste;
    assign bus.E_dstM  = e_q.dstm;
    assign bus.e_valE  = alu_r;
    assign bus.e_valA  = e_q.vala;
    assign bus.e_Cnd   = cnd;
    assign bus.e_dstE  = ((e_q.icode == I_CMOVXX) && !cnd) ? RNONE : e_q.dste;
    assign bus.cc      = cc_q;

endmodule

// File: tb/tb_execute.sv
// Directed vector bench for the Y86-64 execute stage.
module tb_execute;
    import y86_pkg::*;

    logic clk;
    logic rst_n;
    execute_if bus();

    execute dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        bub;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valc;
        logic [63:0] vala;
        logic [63:0] valb;
        logic [3:0]  dste;
        logic [2:0]  mstat;
        logic [2:0]  wstat;
        logic [3:0]  x_icode;
        logic [63:0] x_vale;
        logic [3:0]  x_dste;
        logic        x_cnd;
        logic [2:0]  x_cc;
    } vec_t;

    vec_t vecs[$];
    int   passed;
    int   total;

    function automatic vec_t mk(input logic bub, input logic [3:0] ic, input logic [3:0] fn,
                                input logic [63:0] vc, input logic [63:0] va, input logic [63:0] vb,
                                input logic [3:0] de, input logic [2:0] ms, input logic [2:0] ws,
                                input logic [3:0] xic, input logic [63:0] xve, input logic [3:0] xde,
                                input logic xc, input logic [2:0] xcc);
        vec_t v;
        v.bub = bub; v.icode = ic; v.ifun = fn; v.valc = vc; v.vala = va; v.valb = vb;
        v.dste = de; v.mstat = ms; v.wstat = ws;
        v.x_icode = xic; v.x_vale = xve; v.x_dste = xde; v.x_cnd = xc; v.x_cc = xcc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic drive(input logic bub, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] vc, input logic [63:0] va, input logic [63:0] vb,
                         input logic [3:0] de, input logic [2:0] ms, input logic [2:0] ws);
        bus.E_bubble = bub;
        bus.D_stat   = S_AOK;
        bus.D_icode  = ic;
        bus.D_ifun   = fn;
        bus.D_valC   = vc;
        bus.d_valA   = va;
        bus.d_valB   = vb;
        bus.d_srcA   = 4'h7;
        bus.d_srcB   = 4'h8;
        bus.d_dstE   = de;
        bus.d_dstM   = 4'hF;
        bus.m_stat   = ms;
        bus.W_stat   = ws;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        drive(1'b1, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, S_AOK, S_AOK);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst E_icode", 64'(bus.E_icode), 64'h1);
        chk("rst E_stat",  64'(bus.E_stat),  64'h1);
        chk("rst E_dstE",  64'(bus.E_dstE),  64'hF);
        chk("rst E_srcA",  64'(bus.E_srcA),  64'hF);
        chk("rst cc",      64'(bus.cc),      64'h4);
        chk("rst e_valE",  bus.e_valE,       64'h0);
        chk("rst e_Cnd",   64'(bus.e_Cnd),   64'h1);
        chk("rst e_dstE",  64'(bus.e_dstE),  64'hF);
        chk("rst e_valA",  bus.e_valA,       64'h0);

        @(negedge clk);
        rst_n = 1'b1;

        //         bub  ic    fn    valC     valA                    valB                    dstE  m      W      | icode vale                   dstE cnd cc
        vecs.push_back(mk(0, 4'h6, 4'h1, 64'h0, 64'h5, 64'h3, 4'h2, S_AOK, S_AOK, 4'h6, 64'hFFFF_FFFF_FFFF_FFFE, 4'h2, 1, 3'b100));
        vecs.push_back(mk(0, 4'h2, 4'h1, 64'h0, 64'h55, 64'h0, 4'h3, S_AOK, S_AOK, 4'h2, 64'h55, 4'h3, 1, 3'b010));
        vecs.push_back(mk(0, 4'h2, 4'h3, 64'h0, 64'h77, 64'h0, 4'h3, S_AOK, S_AOK, 4'h2, 64'h77, 4'hF, 0, 3'b010));
        vecs.push_back(mk(0, 4'h6, 4'h0, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h4, S_AOK, S_AOK,
                          4'h6, 64'hFFFF_FFFF_FFFF_FFFE, 4'h4, 1, 3'b010));
        vecs.push_back(mk(0, 4'h6, 4'h3, 64'h0, 64'hAA, 64'hAA, 4'h5, S_AOK, S_AOK, 4'h6, 64'h0, 4'h5, 0, 3'b011));
        vecs.push_back(mk(0, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, S_ADR, S_AOK, 4'h1, 64'h0, 4'hF, 1, 3'b011));
        vecs.push_back(mk(0, 4'h6, 4'h3, 64'h0, 64'hAA, 64'hAA, 4'h5, S_AOK, S_AOK, 4'h6, 64'h0, 4'h5, 0, 3'b011));
        vecs.push_back(mk(0, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, S_AOK, S_AOK, 4'h1, 64'h0, 4'hF, 1, 3'b100));
        vecs.push_back(mk(0, 4'h6, 4'h1, 64'h0, 64'h5, 64'h3, 4'h2, S_AOK, S_AOK, 4'h6, 64'hFFFF_FFFF_FFFF_FFFE, 4'h2, 1, 3'b100));
        vecs.push_back(mk(0, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, S_AOK, S_HLT, 4'h1, 64'h0, 4'hF, 1, 3'b100));
        vecs.push_back(mk(0, 4'hA, 4'h0, 64'h0, 64'h99, 64'h1000, 4'h4, S_AOK, S_AOK, 4'hA, 64'hFF8, 4'h4, 1, 3'b100));
        vecs.push_back(mk(1, 4'h8, 4'h0, 64'h0, 64'h5, 64'h2000, 4'h4, S_AOK, S_AOK, 4'h1, 64'h0, 4'hF, 1, 3'b100));
        vecs.push_back(mk(0, 4'h5, 4'h0, 64'h10, 64'h0, 64'h100, 4'hF, S_AOK, S_AOK, 4'h5, 64'h110, 4'hF, 1, 3'b100));
        vecs.push_back(mk(0, 4'hB, 4'h0, 64'h0, 64'h0, 64'h200, 4'h4, S_AOK, S_AOK, 4'hB, 64'h208, 4'h4, 1, 3'b100));
        vecs.push_back(mk(0, 4'h8, 4'h0, 64'h0, 64'h0, 64'h300, 4'h4, S_AOK, S_AOK, 4'h8, 64'h2F8, 4'h4, 1, 3'b100));
        vecs.push_back(mk(0, 4'h3, 4'h0, 64'h1234, 64'h0, 64'h999, 4'h6, S_AOK, S_AOK, 4'h3, 64'h1234, 4'h6, 1, 3'b100));
        vecs.push_back(mk(0, 4'h7, 4'h6, 64'h0, 64'h0, 64'h0, 4'hF, S_AOK, S_AOK, 4'h7, 64'h0, 4'hF, 0, 3'b100));
        vecs.push_back(mk(0, 4'h6, 4'h2, 64'h0, 64'hF0, 64'h3C, 4'h1, S_AOK, S_AOK, 4'h6, 64'h30, 4'h1, 0, 3'b100));
        vecs.push_back(mk(0, 4'h6, 4'h7, 64'h0, 64'h1, 64'h2, 4'h1, S_AOK, S_AOK, 4'h6, 64'h3, 4'h1, 0, 3'b000));
        vecs.push_back(mk(0, 4'h7, 4'h4, 64'h0, 64'h0, 64'h0, 4'hF, S_AOK, S_AOK, 4'h7, 64'h0, 4'hF, 1, 3'b000));
        vecs.push_back(mk(0, 4'h7, 4'h5, 64'h0, 64'h0, 64'h0, 4'hF, S_AOK, S_AOK, 4'h7, 64'h0, 4'hF, 1, 3'b000));
        vecs.push_back(mk(0, 4'h6, 4'h1, 64'h0, 64'h1, 64'h8000_0000_0000_0000, 4'h1, S_AOK, S_AOK,
                          4'h6, 64'h7FFF_FFFF_FFFF_FFFF, 4'h1, 0, 3'b000));
        vecs.push_back(mk(0, 4'h7, 4'h2, 64'h0, 64'h0, 64'h0, 4'hF, S_AOK, S_AOK, 4'h7, 64'h0, 4'hF, 1, 3'b001));
        vecs.push_back(mk(0, 4'h7, 4'h1, 64'h0, 64'h0, 64'h0, 4'hF, S_AOK, S_AOK, 4'h7, 64'h0, 4'hF, 1, 3'b001));
        vecs.push_back(mk(0, 4'h7, 4'h6, 64'h0, 64'h0, 64'h0, 4'hF, S_AOK, S_AOK, 4'h7, 64'h0, 4'hF, 0, 3'b001));
        vecs.push_back(mk(0, 4'h6, 4'h3, 64'h0, 64'hAA, 64'hAA, 4'h5, S_AOK, S_AOK, 4'h6, 64'h0, 4'h5, 0, 3'b001));
        vecs.push_back(mk(1, 4'h8, 4'h0, 64'h0, 64'h0, 64'h400, 4'h4, S_AOK, S_AOK, 4'h1, 64'h0, 4'hF, 1, 3'b100));

        foreach (vecs[i]) begin
            vec_t v;
            string n;
            v = vecs[i];
            @(negedge clk);
            drive(v.bub, v.icode, v.ifun, v.valc, v.vala, v.valb, v.dste, v.mstat, v.wstat);
            @(posedge clk);
            #1;
            n = $sformatf("v%0d", i);
            chk({n, " E_icode"}, 64'(bus.E_icode), 64'(v.x_icode));
            chk({n, " e_valE"},  bus.e_valE,       v.x_vale);
            chk({n, " e_dstE"},  64'(bus.e_dstE),  64'(v.x_dste));
            chk({n, " e_Cnd"},   64'(bus.e_Cnd),   64'(v.x_cnd));
            chk({n, " cc"},      64'(bus.cc),      64'(v.x_cc));
            chk({n, " e_valA"},  bus.e_valA,       v.bub ? 64'h0 : v.vala);
        end

        // SUB commits cc=010, then reset mid-instruction discards the ADD in E
        @(negedge clk);
        drive(0, 4'h6, 4'h1, 64'h0, 64'h5, 64'h3, 4'h2, S_AOK, S_AOK);
        @(negedge clk);
        drive(0, 4'h6, 4'h0, 64'h0, 64'h1, 64'h2, 4'h3, S_AOK, S_AOK);
        @(posedge clk);
        #1;
        chk("pre-rst cc",     64'(bus.cc), 64'h2);
        chk("pre-rst e_valE", bus.e_valE,  64'h3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async rst E_icode", 64'(bus.E_icode), 64'h1);
        chk("async rst cc",      64'(bus.cc),      64'h4);
        chk("async rst e_valE",  bus.e_valE,       64'h0);
        chk("async rst e_dstE",  64'(bus.e_dstE),  64'hF);
        chk("async rst e_Cnd",   64'(bus.e_Cnd),   64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 4'h3, 4'h0, 64'h42, 64'h0, 64'h0, 4'h3, S_AOK, S_AOK);
        @(posedge clk);
        #1;
        chk("post-rst E_icode", 64'(bus.E_icode), 64'h3);
        chk("post-rst e_valE",  bus.e_valE,       64'h42);
        chk("post-rst e_dstE",  64'(bus.e_dstE),  64'h3);
        chk("post-rst cc",      64'(bus.cc),      64'h4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
